tap_capture_reg: RTL and testbench
==================================

# tap_capture_reg

Parametrised multi-channel capture register with per-channel programmable tap bits. Each channel holds a WIDTH-bit word written over a valid/ready port. Each channel drives a continuous enable output equal to one selectable bit of its stored word, and counts rising edges of that enable. It sits between a configuration/data source and downstream logic that consumes single-bit enables derived from stored control words.

## Interface
- WIDTH, 8, data word width per channel (≥2)
- CHANNELS, 4, number of channels (≥2)
- CNT_W, 8, width of per-channel rise counter
- TAP_W, $clog2(WIDTH), derived, tap index width
- CH_W, $clog2(CHANNELS), derived, channel index width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high together with wr_valid
- wr_ch  in  CH_W  target channel of write
- wr_data  in  WIDTH  word to store
- cfg_we  in  1  tap-select update strobe
- cfg_ch  in  CH_W  channel whose tap is updated
- cfg_tap  in  TAP_W  new tap index
- clr  in  1  synchronous clear of all rise counters
- en  out  CHANNELS  en[c] = data[c][tap[c]], combinational from registers
- loaded  out  CHANNELS  channel written at least once since reset
- rd_ch  in  CH_W  read-back channel select
- rd_data  out  WIDTH  registered stored word of rd_ch
- rd_tap  out  TAP_W  registered tap index of rd_ch
- rd_cnt  out  CNT_W  registered rise count of rd_ch

## Operation
- Reset (rst_n low, async): all data[c]=0, tap[c]=3 if WIDTH>3 else 0, loaded=0, en_q=0, counters=0, rd_data/rd_tap/rd_cnt=0. Every output is defined immediately; no X after reset.
- wr_ready = !cfg_we. Config has priority: a write and a config in the same cycle stall the write. The write is not accepted, and the source holds it.
- Accepted write (wr_valid & wr_ready): data[wr_ch] <= wr_data, loaded[wr_ch] <= 1.
- cfg_we: tap[cfg_ch] <= cfg_tap. cfg_tap ≥ WIDTH is clamped to WIDTH-1.
- en[c] is a continuous function of data[c] and tap[c]. It has no registering.
- Edge detect: en_q <= en every cycle. rise[c] = en[c] & !en_q[c].
- Counter: if clr then cnt[c] <= 0, and this wins over a simultaneous rise. Else if rise[c] and cnt[c] != all-ones then cnt[c] <= cnt[c]+1. The counter saturates and never wraps.
- A rise caused by a tap change counts the same as a rise caused by a data write. A falling transition never counts.
- Rewriting the same value, or writing a value whose tap bit is unchanged, produces no count.
- Read port: rd_data/rd_tap/rd_cnt <= data/tap/cnt[rd_ch] every cycle. The read port reflects register state before the current edge's updates.
- Out-of-range channel index (≥ CHANNELS, non-power-of-two CHANNELS): writes and configs are ignored, reads return 0.

## Timing
- Write accepted at edge N → data and en visible after edge N (same cycle as the register update) → rise counted at edge N+1 → rd_cnt shows it after edge N+2 if rd_ch is held.
- rd_* latency: 1 cycle from rd_ch to outputs.
- wr_ready is combinational from cfg_we only; there is no dependency on wr_valid.
- Reset mid-operation: all state clears asynchronously. The first edge after deassertion behaves as post-reset, with en_q=0 and en=0, so no spurious count.
- Back-to-back writes to one channel: one per cycle. The last value wins for en. Every 0→1 of en seen across consecutive cycles counts.

## Test plan
- Reset release, no stimulus -> en=0, loaded=0, wr_ready=1, rd_data=0x00, rd_tap=3, rd_cnt=0 on all channels.
- Write ch0=0x69 (tap 3) -> en[0]=1 after the write edge, loaded[0]=1, rd_data=0x69, rd_cnt(ch0)=1 two cycles later; other channels unchanged.
- cfg ch0 tap=2 (bit2 of 0x69=0) then tap=0 (bit0=1) -> en[0] goes 0 then 1; rd_cnt(ch0)=2; write 0x69 again -> count stays 2.
- cfg_we and wr_valid asserted together -> wr_ready=0; write is not taken; write completes on the next cycle after cfg_we drops.
- CNT_W=2: toggle ch1 bit3 via writes 0x08/0x00 five times -> rd_cnt saturates at 3; clr coincident with a rise -> rd_cnt=0.
- rst_n pulsed low mid-sequence with en[2]=1 -> all outputs 0 immediately; after release, no count increment without a new rise.

Source files
------------

// File: rtl/tap_capture_reg.sv
// tap_capture_reg: multi-channel capture register with per-channel tap select.
// Each channel stores a WIDTH-bit word. Its enable output is one selectable
// bit of that word, and a saturating counter counts the enable's rising edges.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready    write handshake; wr_ready = !cfg_we (config wins)
//   wr_ch, wr_data       target channel and word for an accepted write
//   cfg_we/cfg_ch/cfg_tap  tap-select update (tap clamped to WIDTH-1)
//   clr                  synchronous clear of all rise counters
//   en                   combinational en[c] = data[c][tap[c]]
//   loaded               channel written at least once since reset
//   rd_ch                read-back channel select
//   rd_data/rd_tap/rd_cnt  registered read-back of rd_ch (1-cycle latency)
module tap_capture_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TAP_W    = $clog2(WIDTH),
  parameter int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [TAP_W-1:0]    cfg_tap,
  input  logic                clr,
  output logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] loaded,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [WIDTH-1:0]    rd_data,
  output logic [TAP_W-1:0]    rd_tap,
  output logic [CNT_W-1:0]    rd_cnt
);

  localparam logic [TAP_W-1:0] TAP_RST = (WIDTH > 3) ? TAP_W'(3) : '0;
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Channel state
  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [WIDTH-1:0]    data_d [CHANNELS];
  logic [TAP_W-1:0]    tap_q  [CHANNELS];
  logic [TAP_W-1:0]    tap_d  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] loaded_q, loaded_d;
  logic [CHANNELS-1:0] en_q;

  // Read-back registers
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [TAP_W-1:0]    rd_tap_q,  rd_tap_d;
  logic [CNT_W-1:0]    rd_cnt_q,  rd_cnt_d;

  // Decoded controls
  logic                wr_fire;
  logic                wr_ch_ok, cfg_ch_ok, rd_ch_ok;
  logic [TAP_W-1:0]    cfg_tap_clamped;
  logic [CHANNELS-1:0] rise;

  // Handshake and index range checks (non-power-of-two CHANNELS)
  always_comb begin
    wr_ready        = !cfg_we;
    wr_fire         = wr_valid && !cfg_we;
    wr_ch_ok        = 32'(wr_ch)  < CHANNELS;
    cfg_ch_ok       = 32'(cfg_ch) < CHANNELS;
    rd_ch_ok        = 32'(rd_ch)  < CHANNELS;
    cfg_tap_clamped = (32'(cfg_tap) > WIDTH - 1) ? TAP_MAX : cfg_tap;
  end

  // Enable taps straight from the stored registers; rise against last cycle
  always_comb begin
    en = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      en[c] = data_q[c][tap_q[c]];
    end
    rise = en & ~en_q;
  end

  // Next-state for data, tap, loaded flags and counters
  always_comb begin
    loaded_d = loaded_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      data_d[c] = data_q[c];
      tap_d[c]  = tap_q[c];
      cnt_d[c]  = cnt_q[c];

      if (wr_fire && wr_ch_ok && (wr_ch == CH_W'(c))) begin
        data_d[c]   = wr_data;
        loaded_d[c] = 1'b1;
      end

      if (cfg_we && cfg_ch_ok && (cfg_ch == CH_W'(c))) begin
        tap_d[c] = cfg_tap_clamped;
      end

      // Clear wins over a coincident rise; counter saturates
      if (clr) begin
        cnt_d[c] = '0;
      end else if (rise[c] && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // Read-back mux samples pre-update state; out-of-range returns zero
  always_comb begin
    rd_data_d = '0;
    rd_tap_d  = '0;
    rd_cnt_d  = '0;
    if (rd_ch_ok) begin
      rd_data_d = data_q[rd_ch];
      rd_tap_d  = tap_q[rd_ch];
      rd_cnt_d  = cnt_q[rd_ch];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        data_q[c] <= '0;
        tap_q[c]  <= TAP_RST;
        cnt_q[c]  <= '0;
      end
      loaded_q  <= '0;
      en_q      <= '0;
      rd_data_q <= '0;
      rd_tap_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        data_q[c] <= data_d[c];
        tap_q[c]  <= tap_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      loaded_q  <= loaded_d;
      en_q      <= en;
      rd_data_q <= rd_data_d;
      rd_tap_q  <= rd_tap_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign loaded  = loaded_q;
  assign rd_data = rd_data_q;
  assign rd_tap  = rd_tap_q;
  assign rd_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_tap_capture_reg.sv
// tb_tap_capture_reg: directed-vector bench for tap_capture_reg.
// Runs with CNT_W=2 so counter saturation is reachable in a few writes.
module tb_tap_capture_reg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned TAP_W    = 3;
  localparam int unsigned CH_W     = 2;

  logic                clk;
  logic                rst_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_data;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [TAP_W-1:0]    cfg_tap;
  logic                clr;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] loaded;
  logic [CH_W-1:0]     rd_ch;
  logic [WIDTH-1:0]    rd_data;
  logic [TAP_W-1:0]    rd_tap;
  logic [CNT_W-1:0]    rd_cnt;

  int checks   = 0;
  int failures = 0;

  tap_capture_reg #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W),
    .TAP_W(TAP_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_data(wr_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap), .clr(clr),
    .en(en), .loaded(loaded),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_tap(rd_tap), .rd_cnt(rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_tap = '0; clr = 1'b0; rd_ch = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_en",       32'(en),       32'h0);
    chk("rst_loaded",   32'(loaded),   32'h0);
    chk("rst_rd_data",  32'(rd_data),  32'h0);
    chk("rst_rd_tap",   32'(rd_tap),   32'h0);
    chk("rst_rd_cnt",   32'(rd_cnt),   32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      tick();
      chk("post_rst_data", 32'(rd_data), 32'h00);
      chk("post_rst_tap",  32'(rd_tap),  32'h3);
      chk("post_rst_cnt",  32'(rd_cnt),  32'h0);
    end

    // Write ch0 = 0x69, tap 3 -> bit3 = 1
    rd_ch = 2'd0;
    wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 8'h69;
    tick();
    wr_valid = 1'b0;
    chk("wr0_en",       32'(en),      32'h1);
    chk("wr0_loaded",   32'(loaded),  32'h1);
    chk("wr0_rd_old",   32'(rd_data), 32'h00);
    tick();
    chk("wr0_rd_data",  32'(rd_data), 32'h69);
    chk("wr0_cnt_lag",  32'(rd_cnt),  32'h0);
    tick();
    chk("wr0_cnt",      32'(rd_cnt),  32'h1);

    // Tap 2 (bit2 of 0x69 = 0) then tap 0 (bit0 = 1)
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_tap = 3'd2;
    tick();
    cfg_we = 1'b0;
    chk("tap2_en0", 32'(en[0]), 32'h0);
    tick();
    cfg_we = 1'b1; cfg_tap = 3'd0;
    tick();
    cfg_we = 1'b0;
    chk("tap0_en0", 32'(en[0]),  32'h1);
    tick();
    chk("tap0_rd_tap", 32'(rd_tap), 32'h0);
    tick();
    chk("tap_rise_cnt", 32'(rd_cnt), 32'h2);

    // Rewrite same value: no new count
    wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 8'h69;
    tick();
    wr_valid = 1'b0;
    repeat (2) tick();
    chk("rewrite_cnt", 32'(rd_cnt), 32'h2);
    chk("rewrite_en0", 32'(en[0]),  32'h1);

    // Config and write together: write stalls, completes after cfg_we drops
    wr_valid = 1'b1; wr_ch = 2'd3; wr_data = 8'hFF;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_tap = 3'd7;
    #1;
    chk("stall_ready", 32'(wr_ready), 32'h0);
    tick();
    chk("stall_loaded", 32'(loaded), 32'h1);
    chk("stall_en",     32'(en),     32'h1);
    cfg_we = 1'b0;
    #1;
    chk("unstall_ready", 32'(wr_ready), 32'h1);
    tick();
    wr_valid = 1'b0;
    chk("unstall_loaded", 32'(loaded), 32'h9);
    chk("unstall_en",     32'(en),     32'h9);
    rd_ch = 2'd3;
    tick();
    chk("ch3_rd_data", 32'(rd_data), 32'hFF);
    chk("ch3_rd_tap",  32'(rd_tap),  32'h7);

    // Five rises on ch1 bit3 saturate a 2-bit counter at 3
    rd_ch = 2'd1;
    wr_valid = 1'b1; wr_ch = 2'd1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h08; tick();
      wr_data = 8'h00; tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("sat_cnt", 32'(rd_cnt), 32'h3);
    chk("sat_en1", 32'(en[1]),  32'h0);

    // Clear coincident with a rise: clear wins
    wr_valid = 1'b1; wr_ch = 2'd1; wr_data = 8'h08;
    tick();
    wr_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_rise_cnt", 32'(rd_cnt), 32'h0);
    tick();
    chk("clr_hold_cnt", 32'(rd_cnt), 32'h0);
    rd_ch = 2'd0;
    tick();
    chk("clr_ch0_cnt", 32'(rd_cnt), 32'h0);

    // Reset pulse mid-sequence with en[2] = 1
    wr_valid = 1'b1; wr_ch = 2'd2; wr_data = 8'h08;
    tick();
    wr_valid = 1'b0;
    rd_ch = 2'd2;
    repeat (2) tick();
    chk("pre_rst_cnt2", 32'(rd_cnt), 32'h1);
    chk("pre_rst_en2",  32'(en[2]),  32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",      32'(en),      32'h0);
    chk("mid_rst_loaded",  32'(loaded),  32'h0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'h0);
    chk("mid_rst_rd_tap",  32'(rd_tap),  32'h0);
    chk("mid_rst_rd_cnt",  32'(rd_cnt),  32'h0);
    #2 rst_n = 1'b1;
    repeat (2) tick();
    chk("post_mid_en",   32'(en),     32'h0);
    chk("post_mid_cnt",  32'(rd_cnt), 32'h0);
    chk("post_mid_tap",  32'(rd_tap), 32'h3);
    tick();
    chk("post_mid_cnt2", 32'(rd_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
